// File: rtl/reg_bus_initiator_if.sv
// Purpose: request/response channels and register-file bus of the register bus initiator.
// Ports: master = initiator view (drives req_ready, rsp_*, RegWrite/addr/write_data);
//        slave  = environment view (upstream controller plus register-file responder).
interface reg_bus_initiator_if #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // upstream request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0]  req_wdata;

    // upstream response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [REG_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;

    // register-file bus
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  write_data;
    logic [REG_WIDTH-1:0]  read_data;
    logic                  valid;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, read_data, valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, RegWrite, addr, write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, read_data, valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, RegWrite, addr, write_data
    );
endinterface

// File: rtl/reg_bus_initiator.sv
// Purpose: executes one register read/write request at a time as a single register-file bus access.
// Latency: accept N, RegWrite pulse N+1, capture N+2, rsp_valid N+3 (illegal address: rsp_valid N+1).
// Backpressure: req_ready low from acceptance until the response handshake; response held until rsp_ready.
// Ports: clk, rst_n (async active-low), bus (master modport: request, response and bus signals).
module reg_bus_initiator #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_ADDR   = 32'h18,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_bus_initiator_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR_L = ADDR_WIDTH'(MAX_ADDR);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [REG_WIDTH-1:0]  rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  regwrite_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]  write_data_q;
    logic                  wr_q;        // direction of the transaction in flight
    logic [CNT_W-1:0]      cnt_q;

    logic addr_legal;

    // Word-aligned and inside the register window.
    assign addr_legal = (bus.req_addr[1:0] == 2'b00) && (bus.req_addr <= MAX_ADDR_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            addr_q       <= '0;
            write_data_q <= '0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= bus.req_write;
                        if (addr_legal) begin
                            // Bus outputs load here so the strobe is visible in the ISSUE cycle.
                            addr_q       <= bus.req_addr;
                            write_data_q <= bus.req_wdata;
                            regwrite_q   <= bus.req_write;
                            state_q      <= ST_ISSUE;
                        end else begin
                            // Rejected without touching the bus.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end
                    end
                end

                ST_ISSUE: begin
                    regwrite_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.valid) begin
                        rsp_rdata_q <= wr_q ? '0 : bus.read_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    regwrite_q  <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.RegWrite   = regwrite_q;
    assign bus.addr       = addr_q;
    assign bus.write_data = write_data_q;

endmodule
